// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: funct3 encodings, FSM states and the MEM/WB record.
package mem_stage_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] alu_out;
        logic [31:0] rd_data;
        logic [4:0]  rd;
        logic        reg_wb_en;
        logic [1:0]  wb_sel;
        logic [31:0] pc;
        logic        is_mem;
    } mem_wb_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane steering: store data/byte enables, misalignment and load extension.
// Zero latency; no flow control of its own.
module load_store_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_o,
    output logic        misaligned_o,
    output logic [31:0] load_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        wdata_o      = store_data_i;
        be_o         = 4'b1111;
        misaligned_o = 1'b0;
        load_data_o  = rdata_i;

        case (funct3_i[1:0])
            2'b00: begin
                wdata_o     = {4{store_data_i[7:0]}};
                be_o        = 4'b0001 << addr_lo_i;
                load_data_o = funct3_i[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            2'b01: begin
                wdata_o      = {2{store_data_i[15:0]}};
                be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                misaligned_o = addr_lo_i[0];
                load_data_o  = funct3_i[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            // Encoding 11 is not a legal size; it is handled as a word access.
            default: begin
                misaligned_o = (addr_lo_i != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: req/ack data-memory handshake feeding the MEM/WB register; 1 cycle for
// non-memory ops, N+1 for an access with N wait cycles; busywait_o stalls upstream while pending.
module memory_access_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  busywait_i,
    input  logic [31:0]           alu_out_ex_mem_i,
    input  logic [31:0]           rs2_ex_mem_i,
    input  logic [2:0]            funct3_ex_mem_i,
    input  logic                  is_load_instr_ex_mem_i,
    input  logic                  is_store_instr_ex_mem_i,
    input  logic                  reg_wb_en_ex_mem_i,
    input  logic [4:0]            rd_ex_mem_i,
    input  logic [1:0]            wb_sel_ex_mem_i,
    input  logic [31:0]           pc_ex_mem_i,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [ADDR_WIDTH-1:0] dmem_addr_o,
    output logic [31:0]           dmem_wdata_o,
    output logic [3:0]            dmem_be_o,
    input  logic                  dmem_ack_i,
    input  logic [31:0]           dmem_rdata_i,
    output logic                  busywait_o,
    output logic                  misaligned_o,
    output logic [31:0]           alu_out_mem_wb_o,
    output logic [31:0]           rd_data_mem_wb_o,
    output logic [4:0]            rd_mem_wb_o,
    output logic                  reg_wb_en_mem_wb_o,
    output logic [1:0]            wb_sel_mem_wb_o,
    output logic [31:0]           pc_mem_wb_o,
    output logic                  is_memory_instruction_mem_wb_o
);

    state_e      state_q, state_d;
    mem_wb_t     mem_wb_q, mem_wb_d;
    logic [31:0] load_buf_q, load_buf_d;
    logic        misaligned_q, misaligned_d;

    logic        mem_op, misaligned, issue;
    logic        req, busy, done, capture;
    logic        mis_raw;
    logic [31:0] wdata, load_data, wb_data;
    logic [3:0]  be;

    load_store_align u_align (
        .addr_lo_i    (alu_out_ex_mem_i[1:0]),
        .funct3_i     (funct3_ex_mem_i),
        .store_data_i (rs2_ex_mem_i),
        .rdata_i      (dmem_rdata_i),
        .wdata_o      (wdata),
        .be_o         (be),
        .misaligned_o (mis_raw),
        .load_data_o  (load_data)
    );

    assign mem_op     = is_load_instr_ex_mem_i | is_store_instr_ex_mem_i;
    assign misaligned = mem_op & mis_raw;
    assign issue      = mem_op & ~misaligned;

    always_comb begin
        state_d      = state_q;
        mem_wb_d     = mem_wb_q;
        load_buf_d   = load_buf_q;
        misaligned_d = 1'b0;
        req          = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        wb_data      = (is_load_instr_ex_mem_i && !misaligned) ? load_data : 32'b0;

        case (state_q)
            IDLE: begin
                if (issue) begin
                    req = 1'b1;
                    if (dmem_ack_i) begin
                        done = 1'b1;
                    end else begin
                        busy    = 1'b1;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                req = 1'b1;
                if (dmem_ack_i) begin
                    done = 1'b1;
                end else begin
                    busy = 1'b1;
                end
            end
            HOLD: begin
                // Read data was consumed from the bus already; replay it from the buffer.
                wb_data = load_buf_q;
                if (!busywait_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (done) begin
            if (busywait_i) begin
                load_buf_d = wb_data;
                state_d    = HOLD;
            end else begin
                state_d = IDLE;
            end
        end

        capture = !busy && !busywait_i;
        if (capture) begin
            mem_wb_d.alu_out   = alu_out_ex_mem_i;
            mem_wb_d.rd_data   = wb_data;
            mem_wb_d.rd        = rd_ex_mem_i;
            mem_wb_d.reg_wb_en = reg_wb_en_ex_mem_i & ~misaligned;
            mem_wb_d.wb_sel    = wb_sel_ex_mem_i;
            mem_wb_d.pc        = pc_ex_mem_i;
            mem_wb_d.is_mem    = mem_op;
            misaligned_d       = misaligned;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            mem_wb_q     <= '0;
            load_buf_q   <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_wb_q     <= mem_wb_d;
            load_buf_q   <= load_buf_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Request side is gated by reset so an abandoned access drops without waiting for a clock.
    assign dmem_req_o   = req & rst_ni;
    assign dmem_we_o    = dmem_req_o & is_store_instr_ex_mem_i;
    assign dmem_addr_o  = dmem_req_o ? {alu_out_ex_mem_i[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign dmem_wdata_o = dmem_req_o ? wdata : 32'b0;
    assign dmem_be_o    = dmem_req_o ? be : 4'b0;
    assign busywait_o   = busy & rst_ni;
    assign misaligned_o = misaligned_q;

    assign alu_out_mem_wb_o               = mem_wb_q.alu_out;
    assign rd_data_mem_wb_o               = mem_wb_q.rd_data;
    assign rd_mem_wb_o                    = mem_wb_q.rd;
    assign reg_wb_en_mem_wb_o             = mem_wb_q.reg_wb_en;
    assign wb_sel_mem_wb_o                = mem_wb_q.wb_sel;
    assign pc_mem_wb_o                    = mem_wb_q.pc;
    assign is_memory_instruction_mem_wb_o = mem_wb_q.is_mem;

endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboard bench for memory_access_stage: directed loads/stores, wait states, stalls and reset.
module tb_memory_access_stage;
    import mem_stage_pkg::*;

    typedef struct packed {
        logic [31:0] alu_out;
        logic [31:0] rd_data;
        logic [4:0]  rd;
        logic        wben;
        logic [1:0]  wb_sel;
        logic [31:0] pc;
        logic        is_mem;
        logic        mis;
    } wb_exp_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        chk_data;
    } req_exp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        busywait_i = 1'b0;
    logic [31:0] alu_out_ex_mem_i = '0;
    logic [31:0] rs2_ex_mem_i = '0;
    logic [2:0]  funct3_ex_mem_i = '0;
    logic        is_load_instr_ex_mem_i = 1'b0;
    logic        is_store_instr_ex_mem_i = 1'b0;
    logic        reg_wb_en_ex_mem_i = 1'b0;
    logic [4:0]  rd_ex_mem_i = '0;
    logic [1:0]  wb_sel_ex_mem_i = '0;
    logic [31:0] pc_ex_mem_i = '0;
    logic        dmem_ack_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;
    logic        dmem_req_o, dmem_we_o, busywait_o, misaligned_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] alu_out_mem_wb_o, rd_data_mem_wb_o, pc_mem_wb_o;
    logic [4:0]  rd_mem_wb_o;
    logic        reg_wb_en_mem_wb_o, is_memory_instruction_mem_wb_o;
    logic [1:0]  wb_sel_mem_wb_o;

    wb_exp_t  wb_q[$];
    req_exp_t rq_q[$];
    int       n_tests = 0;
    int       n_fail = 0;
    int       req_cnt = 0;
    logic     instr_vld = 1'b0;
    logic     chk_pending = 1'b0;

    memory_access_stage #(.ADDR_WIDTH(32)) dut (
        .clk_i                          (clk_i),
        .rst_ni                         (rst_ni),
        .busywait_i                     (busywait_i),
        .alu_out_ex_mem_i               (alu_out_ex_mem_i),
        .rs2_ex_mem_i                   (rs2_ex_mem_i),
        .funct3_ex_mem_i                (funct3_ex_mem_i),
        .is_load_instr_ex_mem_i         (is_load_instr_ex_mem_i),
        .is_store_instr_ex_mem_i        (is_store_instr_ex_mem_i),
        .reg_wb_en_ex_mem_i             (reg_wb_en_ex_mem_i),
        .rd_ex_mem_i                    (rd_ex_mem_i),
        .wb_sel_ex_mem_i                (wb_sel_ex_mem_i),
        .pc_ex_mem_i                    (pc_ex_mem_i),
        .dmem_req_o                     (dmem_req_o),
        .dmem_we_o                      (dmem_we_o),
        .dmem_addr_o                    (dmem_addr_o),
        .dmem_wdata_o                   (dmem_wdata_o),
        .dmem_be_o                      (dmem_be_o),
        .dmem_ack_i                     (dmem_ack_i),
        .dmem_rdata_i                   (dmem_rdata_i),
        .busywait_o                     (busywait_o),
        .misaligned_o                   (misaligned_o),
        .alu_out_mem_wb_o               (alu_out_mem_wb_o),
        .rd_data_mem_wb_o               (rd_data_mem_wb_o),
        .rd_mem_wb_o                    (rd_mem_wb_o),
        .reg_wb_en_mem_wb_o             (reg_wb_en_mem_wb_o),
        .wb_sel_mem_wb_o                (wb_sel_mem_wb_o),
        .pc_mem_wb_o                    (pc_mem_wb_o),
        .is_memory_instruction_mem_wb_o (is_memory_instruction_mem_wb_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] all_outs();
        return {dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o, busywait_o,
                misaligned_o, alu_out_mem_wb_o, rd_data_mem_wb_o, rd_mem_wb_o,
                reg_wb_en_mem_wb_o, wb_sel_mem_wb_o, pc_mem_wb_o, is_memory_instruction_mem_wb_o};
    endfunction

    // Monitor: request beats are checked on req&ack, MEM/WB one cycle after an unstalled slot.
    initial begin
        wb_exp_t  e, act;
        req_exp_t r;
        forever begin
            @(negedge clk_i);
            if (dmem_req_o && dmem_ack_i) begin
                req_cnt++;
                if (rq_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL req_unexpected: got addr %0h, none expected", dmem_addr_o);
                end else begin
                    r = rq_q.pop_front();
                    check("req_we_addr", {dmem_we_o, dmem_addr_o}, {r.we, r.addr});
                    if (r.chk_data)
                        check("req_wdata_be", {dmem_wdata_o, dmem_be_o}, {r.wdata, r.be});
                end
            end
            if (chk_pending) begin
                chk_pending = 1'b0;
                if (wb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL mem_wb_unexpected: capture with empty scoreboard");
                end else begin
                    e   = wb_q.pop_front();
                    act = {alu_out_mem_wb_o, rd_data_mem_wb_o, rd_mem_wb_o, reg_wb_en_mem_wb_o,
                           wb_sel_mem_wb_o, pc_mem_wb_o, is_memory_instruction_mem_wb_o, misaligned_o};
                    check("mem_wb", act, e);
                end
            end
            if (rst_ni && instr_vld && !busywait_o && !busywait_i) chk_pending = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic bubble();
        alu_out_ex_mem_i        = '0;
        rs2_ex_mem_i            = '0;
        funct3_ex_mem_i         = '0;
        is_load_instr_ex_mem_i  = 1'b0;
        is_store_instr_ex_mem_i = 1'b0;
        reg_wb_en_ex_mem_i      = 1'b0;
        rd_ex_mem_i             = '0;
        wb_sel_ex_mem_i         = '0;
        pc_ex_mem_i             = '0;
        dmem_ack_i              = 1'b0;
        busywait_i              = 1'b0;
        instr_vld               = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input int idx, input logic [2:0] f3, input logic ld, input logic st,
                         input logic wben, input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [31:0] rdata, input int n_wait, input int hold,
                         input logic [31:0] exp_rd, input logic exp_mis,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        int       busy_cnt;
        int       req0;
        logic     exp_req;
        wb_exp_t  e;
        req_exp_t r;
        exp_req = (ld || st) && !exp_mis;
        e = '{addr, exp_rd, 5'(idx), wben & !exp_mis, 2'b01, 32'h1000 + 32'(idx) * 4,
              ld | st, exp_mis};
        wb_q.push_back(e);
        if (exp_req) begin
            r = '{st, {addr[31:2], 2'b00}, exp_wdata, exp_be, st};
            rq_q.push_back(r);
        end
        alu_out_ex_mem_i        = addr;
        rs2_ex_mem_i            = rs2;
        funct3_ex_mem_i         = f3;
        is_load_instr_ex_mem_i  = ld;
        is_store_instr_ex_mem_i = st;
        reg_wb_en_ex_mem_i      = wben;
        rd_ex_mem_i             = 5'(idx);
        wb_sel_ex_mem_i         = 2'b01;
        pc_ex_mem_i             = 32'h1000 + 32'(idx) * 4;
        dmem_rdata_i            = rdata;
        busywait_i              = (hold > 0);
        instr_vld               = 1'b1;
        req0     = req_cnt;
        busy_cnt = 0;
        for (int c = 0; c <= n_wait; c++) begin
            dmem_ack_i = (c == n_wait);
            @(negedge clk_i);
            if (busywait_o) busy_cnt++;
            @(posedge clk_i);
            #1;
        end
        dmem_ack_i = 1'b0;
        if (hold > 0) begin
            for (int c = 0; c < hold; c++) begin
                dmem_ack_i = 1'b1;
                @(negedge clk_i);
                check($sformatf("hold_frozen_%0d", idx),
                      {dmem_req_o, busywait_o, rd_data_mem_wb_o, reg_wb_en_mem_wb_o,
                       is_memory_instruction_mem_wb_o}, '0);
                @(posedge clk_i);
                #1;
            end
            dmem_ack_i = 1'b0;
            busywait_i = 1'b0;
            @(negedge clk_i);
            @(posedge clk_i);
            #1;
        end
        check($sformatf("busy_cycles_%0d", idx), busy_cnt, exp_req ? n_wait : 0);
        check($sformatf("req_count_%0d", idx), req_cnt - req0, exp_req ? 1 : 0);
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_outputs", all_outs(), '0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        check("idle_after_reset", all_outs(), '0);
        @(posedge clk_i);
        #1;

        issue(1, SW, 1'b0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 2, 0,
              32'h0, 1'b0, 4'b1111, 32'hDEADBEEF);
        bubble();
        issue(2, LB, 1'b1, 1'b0, 1'b1, 32'h103, 32'h0, 32'h80FFFFFF, 0, 0,
              32'hFFFFFF80, 1'b0, 4'b1000, 32'h0);
        bubble();
        issue(3, LBU, 1'b1, 1'b0, 1'b1, 32'h103, 32'h0, 32'h80FFFFFF, 0, 0,
              32'h00000080, 1'b0, 4'b1000, 32'h0);
        bubble();
        issue(4, SH, 1'b0, 1'b1, 1'b0, 32'h102, 32'h00001234, 32'h0, 1, 0,
              32'h0, 1'b0, 4'b1100, 32'h12341234);
        bubble();
        issue(5, LW, 1'b1, 1'b0, 1'b1, 32'h101, 32'h0, 32'h11111111, 0, 0,
              32'h0, 1'b1, 4'b0000, 32'h0);
        bubble();
        @(negedge clk_i);
        check("misaligned_single_pulse", misaligned_o, 1'b0);
        @(posedge clk_i);
        #1;
        issue(6, LH, 1'b1, 1'b0, 1'b1, 32'h102, 32'h0, 32'h80017FFF, 1, 3,
              32'hFFFF8001, 1'b0, 4'b1100, 32'h0);
        bubble();
        issue(7, LHU, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 32'h8001F00D, 0, 0,
              32'h0000F00D, 1'b0, 4'b0011, 32'h0);
        bubble();
        issue(8, 3'b000, 1'b0, 1'b0, 1'b1, 32'hCAFEBABE, 32'h5555, 32'hFFFFFFFF, 0, 0,
              32'h0, 1'b0, 4'b0000, 32'h0);
        bubble();
        issue(9, SB, 1'b0, 1'b1, 1'b0, 32'h101, 32'h000000A5, 32'h0, 3, 0,
              32'h0, 1'b0, 4'b0010, 32'hA5A5A5A5);
        bubble();
        issue(10, LW, 1'b1, 1'b0, 1'b1, 32'h204, 32'h0, 32'h12345678, 0, 2,
              32'h12345678, 1'b0, 4'b1111, 32'h0);
        bubble();
        issue(11, SH, 1'b0, 1'b1, 1'b0, 32'h103, 32'h0000FFFF, 32'h0, 0, 0,
              32'h0, 1'b1, 4'b0000, 32'h0);
        bubble();
        bubble();

        // Abandon an access in WAIT with an asynchronous reset.
        alu_out_ex_mem_i       = 32'h200;
        funct3_ex_mem_i        = LW;
        is_load_instr_ex_mem_i = 1'b1;
        reg_wb_en_ex_mem_i     = 1'b1;
        @(negedge clk_i);
        check("rst_test_idle_req", {dmem_req_o, busywait_o}, 2'b11);
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        check("rst_test_wait_req", {dmem_req_o, busywait_o, dmem_addr_o}, {2'b11, 32'h200});
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst_mid_access", all_outs(), '0);
        @(posedge clk_i);
        #1;
        bubble();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        bubble();
        @(negedge clk_i);
        check("after_rst_outputs", all_outs(), '0);
        check("scoreboard_drained", wb_q.size() + rq_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
